// File: rtl/stim_sequencer_if.sv
// Stimulus sequencer bus: run control, DUT response input, stimulus and status outputs.
// The master modport is the sequencer side; slave is the harness/DUT side.
interface stim_sequencer_if #(
  parameter int IN_W  = 262,
  parameter int OUT_W = 330,
  parameter int CNT_W = 32
) ();
  logic             start_i;
  logic             abort_i;
  logic [31:0]      seed_i;
  logic [CNT_W-1:0] cycles_i;
  logic [OUT_W-1:0] dut_out_i;
  logic [IN_W-1:0]  stim_o;
  logic             stim_valid_o;
  logic [CNT_W-1:0] vec_cnt_o;
  logic             busy_o;
  logic             done_o;
  logic [31:0]      sig_o;

  modport master (
    input  start_i, abort_i, seed_i, cycles_i, dut_out_i,
    output stim_o, stim_valid_o, vec_cnt_o, busy_o, done_o, sig_o
  );

  modport slave (
    output start_i, abort_i, seed_i, cycles_i, dut_out_i,
    input  stim_o, stim_valid_o, vec_cnt_o, busy_o, done_o, sig_o
  );
endinterface

// File: rtl/stim_sequencer.sv
// LCG stimulus sequencer: one 32-bit word per cycle, a full vector every NW cycles,
// responses folded into a 32-bit signature NW cycles after each vector is applied.
module stim_sequencer #(
  parameter int IN_W  = 262,
  parameter int OUT_W = 330,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  stim_sequencer_if.master  bus
);
  localparam int NW     = (IN_W + 31) / 32;
  localparam int LAST_W = IN_W - 32 * (NW - 1);
  localparam int SH_W   = 32 * (NW - 1);
  localparam int NO     = (OUT_W + 31) / 32;
  localparam int KW     = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {IDLE, GEN, DRAIN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [31:0]       rng;
  logic [31:0]       rng_nxt;
  logic [CNT_W-1:0]  target;
  logic [CNT_W-1:0]  vec_cnt;
  logic [KW-1:0]     k;
  logic [SH_W-1:0]   shadow;
  logic [IN_W-1:0]   stim;
  logic              stim_valid;
  logic [31:0]       sig;
  logic [31:0]       sig_fold;
  logic [32*NO-1:0]  resp_pad;
  logic [31:0]       resp_x;
  logic              last_word;
  logic              run_end;
  logic              accept;
  logic              gen_step;
  logic              drain_step;
  logic              emit;
  logic              fold_en;
  logic              busy;
  logic              done;

  assign rng_nxt   = rng * 32'h41C64E6D + 32'h0000_3039;
  assign last_word = (k == KW'(NW - 1));
  // Compared one bit wider so a target of all-ones cannot alias to zero.
  assign run_end   = (({1'b0, vec_cnt} + 1'b1) == ({1'b0, target} + 1'b1));

  always_comb begin
    resp_pad = '0;
    resp_pad[OUT_W-1:0] = bus.dut_out_i;
    resp_x = '0;
    for (int i = 0; i < NO; i++) begin
      resp_x = resp_x ^ resp_pad[32*i +: 32];
    end
    sig_fold = {sig[30:0], sig[31] ^ sig[21] ^ sig[1] ^ sig[0]} ^ resp_x;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start_i) state_nxt = GEN;
      end
      GEN: begin
        if (bus.abort_i)              state_nxt = IDLE;
        else if (last_word && run_end) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (bus.abort_i)     state_nxt = IDLE;
        else if (last_word)  state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == GEN) || (state == DRAIN);
    done       = (state == DONE);
    accept     = ((state == IDLE) || (state == DONE)) && bus.start_i;
    gen_step   = (state == GEN) && !bus.abort_i;
    drain_step = (state == DRAIN) && !bus.abort_i;
    emit       = gen_step && last_word;
    // Vector 0 has no prior response; the final response is folded at the end of DRAIN.
    fold_en    = (emit && (vec_cnt != '0)) || (drain_step && last_word);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rng        <= '0;
      target     <= '0;
      vec_cnt    <= '0;
      k          <= '0;
      shadow     <= '0;
      stim       <= '0;
      stim_valid <= 1'b0;
      sig        <= '0;
    end else begin
      stim_valid <= emit;
      if (accept) begin
        rng     <= bus.seed_i;
        target  <= bus.cycles_i;
        sig     <= '0;
        vec_cnt <= '0;
        k       <= '0;
      end else begin
        if (gen_step) begin
          rng <= rng_nxt;
          if (last_word) begin
            stim    <= {rng_nxt[LAST_W-1:0], shadow};
            vec_cnt <= vec_cnt + CNT_W'(1);
            k       <= '0;
          end else begin
            shadow[32*k +: 32] <= rng_nxt;
            k <= k + 1'b1;
          end
        end
        if (drain_step) begin
          k <= last_word ? '0 : k + 1'b1;
        end
        if (fold_en) begin
          sig <= sig_fold;
        end
      end
    end
  end

  assign bus.stim_o       = stim;
  assign bus.stim_valid_o = stim_valid;
  assign bus.vec_cnt_o    = vec_cnt;
  assign bus.busy_o       = busy;
  assign bus.done_o       = done;
  assign bus.sig_o        = sig;
endmodule

// File: tb/tb_stim_sequencer.sv
// Scoreboard bench: runs push expected vectors/signatures; a negedge monitor pops and compares.
module tb_stim_sequencer;
  localparam int IN_W  = 262;
  localparam int OUT_W = 330;
  localparam int CNT_W = 32;

  typedef logic [511:0] w_t;
  typedef struct {
    logic [IN_W-1:0] vec;
    int              cyc;
  } vec_exp_t;
  typedef struct {
    logic [31:0] sig;
    int          cnt;
    int          cyc;
  } done_exp_t;

  logic clk;
  logic rst_n;
  logic resp_mode;
  logic [OUT_W-1:0] resp_reg;

  int n_tests;
  int n_fail;
  int cyc;
  logic done_prev;
  logic [IN_W-1:0] last_vec;

  vec_exp_t  vec_q[$];
  done_exp_t done_q[$];

  stim_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

  stim_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Response model: a register that reacts to the applied vector one clock later.
  always @(posedge clk) resp_reg <= {~bus.stim_o[67:0], bus.stim_o};
  assign bus.dut_out_i = resp_mode ? resp_reg : '0;

  function automatic logic [31:0] lcg(input logic [31:0] x);
    return x * 32'h41C64E6D + 32'h0000_3039;
  endfunction

  function automatic logic [OUT_W-1:0] resp_f(input logic [IN_W-1:0] v);
    return {~v[67:0], v};
  endfunction

  function automatic logic [31:0] fold(input logic [31:0] s, input logic [OUT_W-1:0] d);
    logic [32*11-1:0] p;
    logic [31:0] x;
    p = '0;
    p[OUT_W-1:0] = d;
    x = '0;
    for (int i = 0; i < 11; i++) x = x ^ p[32*i +: 32];
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ x;
  endfunction

  task automatic gen_vec(inout logic [31:0] r, output logic [IN_W-1:0] v);
    v = '0;
    for (int w = 0; w < 9; w++) begin
      r = lcg(r);
      if (w < 8) v[32*w +: 32] = r;
      else       v[261:256]    = r[5:0];
    end
  endtask

  task automatic chk(input string name, input w_t act, input w_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_run(input logic [31:0] seed, input int cyc_n, input int n_push,
                           input bit with_done, input bit with_abort);
    logic [31:0] r;
    logic [31:0] s;
    logic [IN_W-1:0] v;
    vec_exp_t ve;
    done_exp_t de;
    bus.seed_i   = seed;
    bus.cycles_i = CNT_W'(cyc_n);
    bus.start_i  = 1'b1;
    bus.abort_i  = with_abort;
    r = seed;
    s = '0;
    for (int j = 0; j <= cyc_n; j++) begin
      gen_vec(r, v);
      if (j < n_push) begin
        ve.vec = v;
        ve.cyc = cyc + 10 + 9 * j;
        vec_q.push_back(ve);
        last_vec = v;
      end
      s = fold(s, resp_mode ? resp_f(v) : '0);
    end
    if (with_done) begin
      de.sig = s;
      de.cnt = cyc_n + 1;
      de.cyc = cyc + 1 + 9 * (cyc_n + 2);
      done_q.push_back(de);
    end
    tick();
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && bus.done_o !== 1'b1; i++) tick();
    if (bus.done_o !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: done_o=%b after %0d cycles, expected 1", bus.done_o, budget);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stim"},  w_t'(bus.stim_o),       w_t'(0));
    chk({tag, "_valid"}, w_t'(bus.stim_valid_o), w_t'(0));
    chk({tag, "_cnt"},   w_t'(bus.vec_cnt_o),    w_t'(0));
    chk({tag, "_busy"},  w_t'(bus.busy_o),       w_t'(0));
    chk({tag, "_done"},  w_t'(bus.done_o),       w_t'(0));
    chk({tag, "_sig"},   w_t'(bus.sig_o),        w_t'(0));
  endtask

  // Monitor: pops expectations whenever the DUT presents a vector or completes a run.
  initial begin
    vec_exp_t ve;
    done_exp_t de;
    cyc = 0;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.stim_valid_o === 1'b1) begin
        if (vec_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_stim_valid: pulse at cycle %0d, expected none", cyc);
        end else begin
          ve = vec_q.pop_front();
          chk("stim_vec",   w_t'(bus.stim_o), w_t'(ve.vec));
          chk("stim_cycle", w_t'(cyc),        w_t'(ve.cyc));
          chk("valid_busy", w_t'(bus.busy_o), w_t'(1));
        end
      end
      if (bus.done_o === 1'b1 && done_prev !== 1'b1) begin
        if (done_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: done at cycle %0d, expected none", cyc);
        end else begin
          de = done_q.pop_front();
          chk("done_sig",   w_t'(bus.sig_o),     w_t'(de.sig));
          chk("done_cnt",   w_t'(bus.vec_cnt_o), w_t'(de.cnt));
          chk("done_cycle", w_t'(cyc),           w_t'(de.cyc));
        end
      end
      done_prev = bus.done_o;
    end
  end

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    resp_mode = 1'b0;
    last_vec = '0;
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.seed_i = '0;
    bus.cycles_i = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Abort while idle does nothing.
    bus.abort_i = 1'b1;
    repeat (3) tick();
    bus.abort_i = 1'b0;
    chk("idle_abort_busy", w_t'(bus.busy_o), w_t'(0));
    chk("idle_abort_done", w_t'(bus.done_o), w_t'(0));

    // Seed 1, single vector.
    start_run(32'd1, 0, 1, 1'b1, 1'b0);
    chk("start_busy", w_t'(bus.busy_o), w_t'(1));
    wait_done(40);
    chk("vec0_word0", w_t'(bus.stim_o[31:0]), w_t'(32'h41C67EA6));
    chk("t1_cnt",     w_t'(bus.vec_cnt_o),    w_t'(1));

    // Long run, responses tied low.
    start_run(32'd1512374394, 300, 301, 1'b1, 1'b0);
    wait_done(3000);
    chk("zero_sig", w_t'(bus.sig_o), w_t'(0));

    // Long run with live responses, then the same run again.
    resp_mode = 1'b1;
    start_run(32'd1512374394, 300, 301, 1'b1, 1'b0);
    wait_done(3000);
    start_run(32'd1512374394, 300, 301, 1'b1, 1'b0);
    wait_done(3000);
    resp_mode = 1'b0;

    // Abort while vector 5 is being generated.
    start_run(32'h00C0FFEE, 20, 5, 1'b0, 1'b0);
    for (int i = 0; i < 100 && bus.vec_cnt_o != CNT_W'(5); i++) tick();
    chk("abort_reach5", w_t'(bus.vec_cnt_o), w_t'(5));
    repeat (4) tick();
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    chk("abort_busy", w_t'(bus.busy_o), w_t'(0));
    chk("abort_done", w_t'(bus.done_o), w_t'(0));
    chk("abort_hold", w_t'(bus.stim_o), w_t'(last_vec));
    repeat (30) tick();
    chk("abort_drained", w_t'(vec_q.size()), w_t'(0));
    start_run(32'h00C0FFEE, 0, 1, 1'b1, 1'b0);
    wait_done(40);

    // Reset in DRAIN.
    start_run(32'd7, 0, 1, 1'b0, 1'b0);
    for (int i = 0; i < 20 && bus.stim_valid_o !== 1'b1; i++) tick();
    repeat (3) tick();
    chk("drain_busy", w_t'(bus.busy_o), w_t'(1));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_all_zero("drain_rst");
    tick();

    // Start held high during GEN is ignored.
    start_run(32'd99, 2, 3, 1'b1, 1'b0);
    bus.start_i = 1'b1;
    repeat (15) tick();
    bus.start_i = 1'b0;
    wait_done(100);

    // From DONE: start and abort together restart the run.
    start_run(32'd5, 1, 2, 1'b1, 1'b1);
    chk("restart_done", w_t'(bus.done_o),    w_t'(0));
    chk("restart_busy", w_t'(bus.busy_o),    w_t'(1));
    chk("restart_sig",  w_t'(bus.sig_o),     w_t'(0));
    chk("restart_cnt",  w_t'(bus.vec_cnt_o), w_t'(0));
    wait_done(60);
    tick();

    chk("vec_q_empty",  w_t'(vec_q.size()),  w_t'(0));
    chk("done_q_empty", w_t'(done_q.size()), w_t'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
